pattern_history_predictor: RTL and testbench

- Parametrised successor to the fixed 4-entry predictor behind predictor_if.
- Table of 2^INDEX_W saturating counters (CTR_W bits each).
- Read combinationally in IF to produce a taken/not-taken prediction; trained in MEM when a conditional branch resolves.
- Adds same-cycle update bypass, width/depth parameters, and an optional gshare global-history hash.

---
 rtl/pattern_history_predictor_pkg.sv | 41 ++++
 rtl/pattern_history_predictor_sat_counter.sv | 40 ++++
 rtl/pattern_history_predictor.sv | 86 ++++++++
 tb/tb_pattern_history_predictor.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_history_predictor_pkg.sv
// Shared types and helpers for the pattern history branch predictor:
// MEM-stage opfunc encoding, conditional-branch decode and saturating counter step.
package pattern_history_predictor_pkg;

    localparam int DEF_INDEX_W = 2;
    localparam int DEF_CTR_W   = 2;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ALU = 4'd1,
        OP_LW  = 4'd2,
        OP_SW  = 4'd3,
        OP_BEQ = 4'd4,
        OP_BNE = 4'd5,
        OP_J   = 4'd6,
        OP_JAL = 4'd7,
        OP_JR  = 4'd8
    } opfunc_t;

    function automatic logic is_cond_branch(input opfunc_t op);
        logic r;
        case (op)
            OP_BEQ, OP_BNE: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    // Counters are at most 4 bits wide; callers pass their own ceiling.
    function automatic logic [3:0] sat_update(input logic [3:0] ctr, input logic taken,
                                              input logic [3:0] ctr_max);
        logic [3:0] r;
        if (taken) begin
            r = (ctr >= ctr_max) ? ctr : ctr + 4'd1;
        end else begin
            r = (ctr == 4'd0) ? ctr : ctr - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pattern_history_predictor_sat_counter.sv
// One CTR_W-bit saturating counter; o_next is the value it would take if trained
// this cycle in direction i_dir, exposed so the table can bypass it to IF.
module sat_counter
    import pattern_history_predictor_pkg::*;
#(
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_en,
    input  logic             i_dir,
    output logic [CTR_W-1:0] o_q,
    output logic [CTR_W-1:0] o_next
);

    localparam logic [3:0]       CTR_MAX = 4'((1 << CTR_W) - 1);
    localparam logic [CTR_W-1:0] INIT_V  = CTR_W'(CTR_INIT);

    logic [CTR_W-1:0] r_q;

    // Saturating step computed every cycle, independent of the enable.
    always_comb begin
        o_next = CTR_W'(sat_update(4'(r_q), i_dir, CTR_MAX));
    end

    // Counter storage.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_q <= INIT_V;
        end else if (i_en) begin
            r_q <= o_next;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pattern_history_predictor.sv
// Table of 2**INDEX_W saturating counters: read in IF, trained in MEM, with same-cycle
// bypass. Define PREDICTOR_GSHARE_EN to hash the IF index with a global history register.
module pattern_history_predictor
    import pattern_history_predictor_pkg::*;
#(
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int CTR_W    = DEF_CTR_W,
    parameter int CTR_INIT = 2 ** (CTR_W - 1) - 1
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [INDEX_W-1:0] if_index,
    output logic [INDEX_W-1:0] if_pr_index,
    output logic               PRresult,
    input  logic               mm_en,
    input  opfunc_t            mm_opfunc,
    input  logic [INDEX_W-1:0] mm_prindex,
    input  logic               ABtaken
);

    localparam int DEPTH = 1 << INDEX_W;

    logic               w_train;
    logic               w_bypass;
    logic [INDEX_W-1:0] w_pr_index;
    logic [CTR_W-1:0]   w_eff;
    logic [CTR_W-1:0]   w_ctr  [DEPTH];
    logic [CTR_W-1:0]   w_next [DEPTH];

    // Gating with nRST keeps the prediction at the reset value while reset is held.
    assign w_train = nRST & mm_en & is_cond_branch(mm_opfunc);

`ifdef PREDICTOR_GSHARE_EN
    logic [INDEX_W-1:0] r_ghr;
    logic [INDEX_W-1:0] w_ghr_next;

    if (INDEX_W == 1) begin : g_ghr_one
        assign w_ghr_next = ABtaken;
    end else begin : g_ghr_shift
        assign w_ghr_next = {r_ghr[INDEX_W-2:0], ABtaken};
    end

    // Global history shifts in each resolved conditional branch outcome.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ghr <= '0;
        end else if (w_train) begin
            r_ghr <= w_ghr_next;
        end else begin
            r_ghr <= r_ghr;
        end
    end

    assign w_pr_index = if_index ^ r_ghr;
`else
    assign w_pr_index = if_index;
`endif

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
        sat_counter #(
            .CTR_W    (CTR_W),
            .CTR_INIT (CTR_INIT)
        ) u_ctr (
            .CLK    (CLK),
            .nRST   (nRST),
            .i_en   (w_train && (mm_prindex == INDEX_W'(gi))),
            .i_dir  (ABtaken),
            .o_q    (w_ctr[gi]),
            .o_next (w_next[gi])
        );
    end

    // Select the trained-next value when MEM is updating the entry IF is reading.
    always_comb begin
        w_bypass = w_train && (mm_prindex == w_pr_index);
        if (w_bypass) begin
            w_eff = w_next[w_pr_index];
        end else begin
            w_eff = w_ctr[w_pr_index];
        end
    end

    assign PRresult    = w_eff[CTR_W-1];
    assign if_pr_index = w_pr_index;

endmodule

// File: tb/tb_pattern_history_predictor.sv
// Randomised self-checking bench for pattern_history_predictor (default and INDEX_W=6/CTR_W=3);
// follows PREDICTOR_GSHARE_EN when defined.
module tb_pattern_history_predictor;
    import pattern_history_predictor_pkg::*;

`ifdef PREDICTOR_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    logic       CLK;
    logic       nRST;
    logic [1:0] if_index, mm_prindex, if_pr_index;
    logic       PRresult, mm_en, ABtaken;
    opfunc_t    mm_opfunc;

    logic [5:0] p_if_index, p_mm_prindex, p_pr_index;
    logic       p_pr, p_en, p_taken;
    opfunc_t    p_op;

    int m_ctr[4];
    int m_ghr;
    int p_ctr[64];
    int p_ghr;
    int n_cmp = 0;
    int n_mis = 0;

    pattern_history_predictor dut (
        .CLK(CLK), .nRST(nRST), .if_index(if_index), .if_pr_index(if_pr_index),
        .PRresult(PRresult), .mm_en(mm_en), .mm_opfunc(mm_opfunc),
        .mm_prindex(mm_prindex), .ABtaken(ABtaken)
    );

    pattern_history_predictor #(.INDEX_W(6), .CTR_W(3)) dut_p (
        .CLK(CLK), .nRST(nRST), .if_index(p_if_index), .if_pr_index(p_pr_index),
        .PRresult(p_pr), .mm_en(p_en), .mm_opfunc(p_op),
        .mm_prindex(p_mm_prindex), .ABtaken(p_taken)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int nxt(int v, bit t, int mx);
        if (t) return (v < mx) ? v + 1 : mx;
        return (v > 0) ? v - 1 : 0;
    endfunction

    function automatic bit m_train();
        return mm_en && (mm_opfunc == OP_BEQ || mm_opfunc == OP_BNE);
    endfunction

    function automatic bit p_train();
        return p_en && (p_op == OP_BEQ || p_op == OP_BNE);
    endfunction

    function automatic int exp_idx();
        return GS ? (int'(if_index) ^ m_ghr) : int'(if_index);
    endfunction

    // Predicted taken when the effective counter is in the upper half of its range.
    function automatic bit exp_pr();
        int e, v;
        e = exp_idx();
        v = m_ctr[e];
        if (nRST && m_train() && int'(mm_prindex) == e) v = nxt(v, ABtaken, 3);
        return v >= 2;
    endfunction

    function automatic bit exp_p_pr();
        int e, v;
        e = GS ? (int'(p_if_index) ^ p_ghr) : int'(p_if_index);
        v = p_ctr[e];
        if (nRST && p_train() && int'(p_mm_prindex) == e) v = nxt(v, p_taken, 7);
        return v >= 4;
    endfunction

    // IF index that lands on table entry tgt given the current history.
    function automatic logic [1:0] idx_for(int tgt);
        return 2'(GS ? (tgt ^ m_ghr) : tgt);
    endfunction

    function automatic logic [5:0] p_idx_for(int tgt);
        return 6'(GS ? (tgt ^ p_ghr) : tgt);
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (nRST) begin
            if (m_train()) begin
                m_ctr[mm_prindex] = nxt(m_ctr[mm_prindex], ABtaken, 3);
                m_ghr = ((m_ghr << 1) | int'(ABtaken)) & 3;
            end
            if (p_train()) begin
                p_ctr[p_mm_prindex] = nxt(p_ctr[p_mm_prindex], p_taken, 7);
                p_ghr = ((p_ghr << 1) | int'(p_taken)) & 63;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_ctr[i] = 1;
        for (int i = 0; i < 64; i++) p_ctr[i] = 3;
        m_ghr = 0;
        p_ghr = 0;
    endtask

    task automatic do_reset();
        mm_en = 1'b0;
        p_en  = 1'b0;
        nRST  = 1'b0;
        #3;
        model_reset();
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            if_index = 2'(i); mm_prindex = 2'(i); mm_en = 1'b1; mm_opfunc = OP_BEQ; ABtaken = 1'b1;
            #1;
            n_cmp++;
            if (PRresult !== 1'b0 || if_pr_index !== 2'(i)) begin
                n_mis++;
                $display("FAIL reset_hold idx %0d: got pr=%0b idx=%0d, expected pr=0 idx=%0d", i, PRresult, if_pr_index, i);
            end
        end
        mm_en = 1'b0;
        @(posedge CLK); #1;
        model_reset();
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mm_prindex = 2'(i); mm_en = 1'b1; ABtaken = 1'b1; mm_opfunc = OP_BNE;
            tick(); tick();
        end
        // Mid-run reset with a training update still being driven.
        mm_prindex = 2'd2; ABtaken = 1'b0;
        nRST = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if_index = 2'(i); mm_prindex = 2'(i);
            #1;
            n_cmp++;
            if (PRresult !== 1'b0) begin
                n_mis++;
                $display("FAIL reset_mid idx %0d: got %0b expected 0", i, PRresult);
            end
        end
        mm_en = 1'b0;
        model_reset();
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mm_prindex = 2'(i); mm_en = 1'b1; ABtaken = 1'b1; mm_opfunc = OP_BEQ;
            tick();
            mm_en = 1'b0;
            if_index = idx_for(i);
            #1;
            n_cmp++;
            if (PRresult !== exp_pr() || PRresult !== 1'b1) begin
                n_mis++;
                $display("FAIL reset_value idx %0d: got %0b expected 1 (counter 1 -> 2)", i, PRresult);
            end
        end
    endtask

    task automatic test_saturation();
        int up[5]   = '{2, 3, 3, 3, 3};
        int down[5] = '{2, 1, 0, 0, 0};
        do_reset();
        mm_prindex = 2'd2; mm_opfunc = OP_BEQ;
        for (int k = 0; k < 10; k++) begin
            ABtaken = (k < 5); mm_en = 1'b1;
            tick();
            mm_en = 1'b0; if_index = idx_for(2);
            #1;
            n_cmp++;
            if (PRresult !== bit'((k < 5 ? up[k] : down[k-5]) >= 2)) begin
                n_mis++;
                $display("FAIL saturation step %0d: got %0b expected counter %0d", k, PRresult, k < 5 ? up[k] : down[k-5]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            ABtaken = 1'b1; mm_en = 1'b1;
            tick();
            mm_en = 1'b0; if_index = idx_for(2);
            #1;
            n_cmp++;
            if (PRresult !== bit'(k == 1)) begin
                n_mis++;
                $display("FAIL saturation_floor step %0d: got %0b expected %0b", k, PRresult, k == 1);
            end
        end
    endtask

    task automatic test_bypass();
        do_reset();
        if_index = idx_for(1); mm_prindex = 2'd1; mm_en = 1'b1; mm_opfunc = OP_BEQ; ABtaken = 1'b1;
        #1;
        n_cmp++;
        if (PRresult !== 1'b1) begin
            n_mis++;
            $display("FAIL bypass_hit: got %0b expected 1", PRresult);
        end
        mm_prindex = 2'd0;
        #1;
        n_cmp++;
        if (PRresult !== 1'b0) begin
            n_mis++;
            $display("FAIL bypass_other_entry: got %0b expected 0", PRresult);
        end
        mm_prindex = 2'd1; mm_en = 1'b0;
        #1;
        n_cmp++;
        if (PRresult !== 1'b0) begin
            n_mis++;
            $display("FAIL bypass_no_en: got %0b expected 0", PRresult);
        end
    endtask

    task automatic test_qualification();
        opfunc_t ops[6] = '{OP_J, OP_LW, OP_JAL, OP_JR, OP_SW, OP_ALU};
        do_reset();
        mm_prindex = 2'd3; mm_opfunc = OP_BNE; ABtaken = 1'b1; mm_en = 1'b0;
        tick(); tick(); tick();
        if_index = idx_for(3);
        #1;
        n_cmp++;
        if (PRresult !== 1'b0) begin
            n_mis++;
            $display("FAIL qual_stalled: got %0b expected 0", PRresult);
        end
        mm_en = 1'b1;
        tick();
        mm_en = 1'b0; if_index = idx_for(3);
        #1;
        n_cmp++;
        if (PRresult !== 1'b1) begin
            n_mis++;
            $display("FAIL qual_one_update: got %0b expected 1", PRresult);
        end
        ABtaken = 1'b0; mm_en = 1'b1;
        tick();
        mm_en = 1'b0; if_index = idx_for(3);
        #1;
        n_cmp++;
        if (PRresult !== 1'b0) begin
            n_mis++;
            $display("FAIL qual_exactly_once: got %0b expected 0", PRresult);
        end
        mm_prindex = 2'd0; ABtaken = 1'b1; mm_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mm_opfunc = ops[i];
            tick(); tick();
        end
        mm_en = 1'b0; if_index = idx_for(0);
        #1;
        n_cmp++;
        if (PRresult !== 1'b0 || PRresult !== exp_pr()) begin
            n_mis++;
            $display("FAIL qual_non_branch: got %0b expected 0", PRresult);
        end
    endtask

    task automatic test_random();
        opfunc_t ops[5] = '{OP_BEQ, OP_BNE, OP_J, OP_LW, OP_JR};
        do_reset();
        for (int k = 0; k < 300; k++) begin
            if_index   = 2'($urandom_range(0, 3));
            mm_prindex = 2'($urandom_range(0, 3));
            mm_en      = 1'($urandom_range(0, 3) != 0);
            mm_opfunc  = ops[$urandom_range(0, 4)];
            ABtaken    = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (PRresult !== exp_pr() || int'(if_pr_index) != exp_idx()) begin
                n_mis++;
                $display("FAIL random cycle %0d: got pr=%0b idx=%0d expected pr=%0b idx=%0d", k, PRresult, if_pr_index, exp_pr(), exp_idx());
            end
            tick();
        end
        mm_en = 1'b0;
    endtask

    task automatic test_param();
        do_reset();
        p_if_index = p_idx_for(5);
        #1;
        n_cmp++;
        if (p_pr !== 1'b0) begin
            n_mis++;
            $display("FAIL param_reset: got %0b expected 0", p_pr);
        end
        p_mm_prindex = 6'd63; p_op = OP_BEQ; p_taken = 1'b1; p_en = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        p_en = 1'b0; p_if_index = p_idx_for(63);
        #1;
        n_cmp++;
        if (p_pr !== 1'b1 || p_ctr[63] != 7) begin
            n_mis++;
            $display("FAIL param_idx63: got %0b expected 1", p_pr);
        end
        p_if_index = p_idx_for(0);
        #1;
        n_cmp++;
        if (p_pr !== 1'b0) begin
            n_mis++;
            $display("FAIL param_idx0: got %0b expected 0", p_pr);
        end
        p_en = 1'b1;
        tick();
        p_taken = 1'b0;
        tick(); tick(); tick();
        p_en = 1'b0; p_if_index = p_idx_for(63);
        #1;
        n_cmp++;
        if (p_pr !== 1'b1 || p_pr !== exp_p_pr()) begin
            n_mis++;
            $display("FAIL param_ceiling: got %0b expected 1 (counter 4)", p_pr);
        end
        p_en = 1'b1;
        tick();
        p_en = 1'b0; p_if_index = p_idx_for(63);
        #1;
        n_cmp++;
        if (p_pr !== 1'b0) begin
            n_mis++;
            $display("FAIL param_down: got %0b expected 0 (counter 3)", p_pr);
        end
    endtask

    task automatic test_gshare();
        bit t[3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0] want;
        do_reset();
        mm_prindex = 2'd0; mm_opfunc = OP_BEQ;
        for (int k = 0; k < 3; k++) begin
            ABtaken = t[k]; mm_en = 1'b1;
            tick();
        end
        mm_en = 1'b0; if_index = 2'b01;
        want = GS ? 2'b11 : 2'b01;
        #1;
        n_cmp++;
        if (if_pr_index !== want || int'(if_pr_index) != exp_idx()) begin
            n_mis++;
            $display("FAIL gshare_index: got %0b expected %0b", if_pr_index, want);
        end
    endtask

    initial begin
        nRST = 1'b0; if_index = '0; mm_prindex = '0; mm_en = 1'b0; mm_opfunc = OP_NOP; ABtaken = 1'b0;
        p_if_index = '0; p_mm_prindex = '0; p_en = 1'b0; p_op = OP_NOP; p_taken = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_saturation();
        test_bypass();
        test_qualification();
        test_random();
        test_param();
        test_gshare();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
